// File: rtl/raster_pixel_writer_pkg.sv
// Shared types and helpers for the raster pixel-write consumer: FSM states,
// RGB565 packing and framebuffer clip test.
package raster_pixel_writer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } wr_state_e;

    localparam int RGB565_W = 16;

    function automatic logic [RGB565_W-1:0] pack_rgb565(input logic [7:0] r,
                                                        input logic [7:0] g,
                                                        input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // Signed compares: negative coordinates must clip, not wrap to large values.
    function automatic logic is_clipped(input logic signed [15:0] x,
                                        input logic signed [15:0] y,
                                        input int                 width,
                                        input int                 height);
        return (x < 16'sd0) || (int'(x) >= width) ||
               (y < 16'sd0) || (int'(y) >= height);
    endfunction

endpackage

// File: rtl/raster_pixel_fifo.sv
// Synchronous {addr,data} FIFO with a registered head entry; o_count covers the
// storage array plus the head register.
module raster_pixel_fifo
    import raster_pixel_writer_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
)(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [PW:0]      r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop;
    logic             w_mem_empty;
    logic             w_load;

    assign w_pop       = i_pop && r_valid;
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    // Head refills only from entries written on an earlier edge, which gives
    // the one-cycle presentation delay and keeps back-to-back pops at 1/cycle.
    assign w_load      = (!r_valid || w_pop) && !w_mem_empty;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_head   <= r_mem[r_rd_ptr[PW-1:0]];
                r_valid  <= 1'b1;
            end else if (w_pop) begin
                r_valid  <= 1'b0;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/raster_pixel_writer.sv
// Pixel-write consumer: clips, packs RGB565, computes the framebuffer address,
// buffers requests and signals frame-drain completion.
module raster_pixel_writer
    import raster_pixel_writer_pkg::*;
#(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = 6
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_write_pixel,
    input  logic signed [15:0]            i_x,
    input  logic signed [15:0]            i_y,
    input  logic [7:0]                    i_r,
    input  logic [7:0]                    i_g,
    input  logic [7:0]                    i_b,
    input  logic [ADDR_W-1:0]             i_fb_base,
    input  logic                          i_frame_end,
    input  logic                          i_clear_status,
    output logic                          o_mem_valid,
    input  logic                          i_mem_ready,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [15:0]                   o_mem_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_almost_full,
    output logic                          o_overflow,
    output logic [15:0]                   o_clip_count,
    output logic                          o_frame_done
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_W + RGB565_W;

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic                w_clip;
    logic                w_in_range;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_ev;
    logic                w_full;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_addr;
    logic [15:0]         w_data;
    logic [EW-1:0]       w_head;
    logic [LW-1:0]       w_count;
    logic                r_overflow;
    logic [15:0]         r_clip_count;
    wr_state_e           r_state;
    wr_state_e           w_state_nxt;
    logic                w_frame_done;

    // Assert asynchronously, release on the clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_clip     = i_write_pixel && is_clipped(i_x, i_y, FB_WIDTH, FB_HEIGHT);
    assign w_in_range = i_write_pixel && !w_clip;
    assign w_pop      = o_mem_valid && i_mem_ready;
    assign w_push     = w_in_range && (!w_full || w_pop);
    assign w_ovf_ev   = w_in_range && !w_push;

    assign w_addr = i_fb_base
                  + ADDR_W'(unsigned'(i_y)) * ADDR_W'(FB_WIDTH)
                  + ADDR_W'(unsigned'(i_x));
    assign w_data = pack_rgb565(i_r, i_g, i_b);

    raster_pixel_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (w_rst_n),
        .i_push  (w_push),
        .i_data  ({w_addr, w_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (o_mem_valid),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_mem_addr    = w_head[EW-1:RGB565_W];
    assign o_mem_data    = w_head[RGB565_W-1:0];
    assign o_level       = w_count;
    assign o_almost_full = (w_count >= LW'(AF_LEVEL));

    // A same-edge event wins over clear, leaving overflow=1 / count=1.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_overflow   <= 1'b0;
            r_clip_count <= '0;
        end else if (i_clear_status) begin
            r_overflow   <= w_ovf_ev;
            r_clip_count <= w_clip ? 16'd1 : 16'd0;
        end else begin
            if (w_ovf_ev) begin
                r_overflow <= 1'b1;
            end
            if (w_clip && (r_clip_count != '1)) begin
                r_clip_count <= r_clip_count + 16'd1;
            end
        end
    end

    assign o_overflow   = r_overflow;
    assign o_clip_count = r_clip_count;

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_frame_end) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty && !w_push) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_frame_done = w_frame_done;

endmodule

// File: tb/tb_raster_pixel_writer.sv
// Self-checking bench for raster_pixel_writer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_raster_pixel_writer;

    localparam int W  = 320;
    localparam int H  = 240;
    localparam int AW = 24;
    localparam int D  = 8;
    localparam int AF = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_write_pixel = 1'b0;
    logic signed [15:0]   i_x = '0;
    logic signed [15:0]   i_y = '0;
    logic [7:0]           i_r = '0, i_g = '0, i_b = '0;
    logic [AW-1:0]        i_fb_base = '0;
    logic                 i_frame_end = 1'b0;
    logic                 i_clear_status = 1'b0;
    logic                 i_mem_ready = 1'b0;
    logic                 o_mem_valid;
    logic [AW-1:0]        o_mem_addr;
    logic [15:0]          o_mem_data;
    logic [3:0]           o_level;
    logic                 o_almost_full;
    logic                 o_overflow;
    logic [15:0]          o_clip_count;
    logic                 o_frame_done;

    always #5 clk = ~clk;

    raster_pixel_writer #(
        .FB_WIDTH   (W),
        .FB_HEIGHT  (H),
        .ADDR_W     (AW),
        .FIFO_DEPTH (D),
        .AF_LEVEL   (AF)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_write_pixel  (i_write_pixel),
        .i_x            (i_x),
        .i_y            (i_y),
        .i_r            (i_r),
        .i_g            (i_g),
        .i_b            (i_b),
        .i_fb_base      (i_fb_base),
        .i_frame_end    (i_frame_end),
        .i_clear_status (i_clear_status),
        .o_mem_valid    (o_mem_valid),
        .i_mem_ready    (i_mem_ready),
        .o_mem_addr     (o_mem_addr),
        .o_mem_data     (o_mem_data),
        .o_level        (o_level),
        .o_almost_full  (o_almost_full),
        .o_overflow     (o_overflow),
        .o_clip_count   (o_clip_count),
        .o_frame_done   (o_frame_done)
    );

    // Reference model: queue of pending requests, each with the edge number
    // after which it may first be presented.
    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            avail;
    } ent_t;

    ent_t q[$];
    int   edge_n  = 0;
    bit   m_ovf   = 1'b0;
    int   m_clip  = 0;
    bit   m_drain = 1'b0;
    int   done_seen = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_valid();
        return (q.size() > 0) && (q[0].avail <= edge_n);
    endfunction

    // One clock cycle: drive at negedge, check 1 time unit later, then advance
    // the model across the following rising edge.
    task automatic step(input bit wr, input int x, input int y,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input bit fe, input bit clr, input bit rdy);
        bit     clip, push, pop, ovf_ev;
        int     lvl;
        longint a;
        ent_t   e;
        @(negedge clk);
        i_write_pixel  = wr;
        i_x            = 16'(x);
        i_y            = 16'(y);
        i_r            = r;
        i_g            = g;
        i_b            = b;
        i_frame_end    = fe;
        i_clear_status = clr;
        i_mem_ready    = rdy;
        #1;
        clip = wr && (x < 0 || x >= W || y < 0 || y >= H);
        check("valid", 32'(o_mem_valid), 32'(model_valid()));
        if (model_valid()) begin
            check("addr", 32'(o_mem_addr), 32'(q[0].addr));
            check("data", 32'(o_mem_data), 32'(q[0].data));
        end
        check("level", 32'(o_level), 32'(q.size()));
        check("almost_full", 32'(o_almost_full), 32'(q.size() >= AF));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("clip_count", 32'(o_clip_count), 32'(m_clip));
        check("frame_done", 32'(o_frame_done),
              32'(m_drain && q.size() == 0 && !(wr && !clip)));
        if (o_frame_done) done_seen++;

        @(posedge clk);
        lvl    = q.size();
        pop    = model_valid() && rdy;
        push   = wr && !clip && (lvl < D || pop);
        ovf_ev = wr && !clip && !push;
        edge_n++;

        if (!m_drain && fe) m_drain = 1'b1;
        else if (m_drain && lvl == 0 && !push) m_drain = 1'b0;

        if (clr) begin
            m_ovf  = ovf_ev;
            m_clip = clip ? 1 : 0;
        end else begin
            if (ovf_ev) m_ovf = 1'b1;
            if (clip && m_clip < 65535) m_clip++;
        end

        if (pop) begin
            void'(q.pop_front());
            if (q.size() > 0 && q[0].avail < edge_n) q[0].avail = edge_n;
        end
        if (push) begin
            a       = longint'(i_fb_base) + longint'(y) * W + longint'(x);
            e.addr  = a[AW-1:0];
            e.data  = 16'(((int'(r) / 8) * 2048) + ((int'(g) / 4) * 32) + (int'(b) / 8));
            e.avail = edge_n + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 0, rdy);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        i_write_pixel  = 1'b0;
        i_frame_end    = 1'b0;
        i_clear_status = 1'b0;
        i_mem_ready    = 1'b0;
        #1;
        check("rst_valid", 32'(o_mem_valid), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        check("rst_data", 32'(o_mem_data), 32'd0);
        check("rst_af", 32'(o_almost_full), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_clip", 32'(o_clip_count), 32'd0);
        check("rst_done", 32'(o_frame_done), 32'd0);
        q.delete();
        m_ovf   = 1'b0;
        m_clip  = 0;
        m_drain = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(0, 3);
    endtask

    initial begin
        int d0;
        apply_reset();

        // Single pixel through an idle pipe.
        i_fb_base = 24'h001000;
        step(1, 5, 2, 8'hFF, 8'h80, 8'h08, 0, 0, 1);
        step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 0, 1);
        #2;
        check("single_valid", 32'(o_mem_valid), 32'd1);
        check("single_addr", 32'(o_mem_addr), 32'h1285);
        check("single_data", 32'(o_mem_data), 32'hFC01);
        step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 0, 1);
        #2;
        check("single_once", 32'(o_mem_valid), 32'd0);
        idle(1, 2);

        // Clipping at each edge of the framebuffer.
        step(1, -1, 0, 8'h11, 8'h22, 8'h33, 0, 0, 1);
        step(1, 320, 0, 8'h11, 8'h22, 8'h33, 0, 0, 1);
        step(1, 0, 240, 8'h11, 8'h22, 8'h33, 0, 0, 1);
        step(1, 319, 239, 8'h11, 8'h22, 8'h33, 0, 0, 1);
        step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 0, 0);
        #2;
        check("clip_addr", 32'(o_mem_addr), 32'h1000 + 32'd76799);
        check("clip_count3", 32'(o_clip_count), 32'd3);
        idle(1, 3);

        // Fill under backpressure, overflow, then full-with-pop, then drain.
        for (int i = 0; i < 9; i++) step(1, i, 7, 8'(i * 20), 8'(i * 9), 8'(i * 3), 0, 0, 0);
        #2;
        check("bp_level", 32'(o_level), 32'd8);
        check("bp_af", 32'(o_almost_full), 32'd1);
        check("bp_ovf", 32'(o_overflow), 32'd1);
        step(1, 100, 100, 8'hA5, 8'h5A, 8'hC3, 0, 0, 1);
        #2;
        check("full_pushpop_level", 32'(o_level), 32'd8);
        step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 1, 1);
        #2;
        check("clear_ovf", 32'(o_overflow), 32'd0);
        idle(1, 10);

        // Frame drain with late ready.
        d0 = done_seen;
        for (int i = 0; i < 3; i++) step(1, 10 + i, 20, 8'h40, 8'h80, 8'hC0, 0, 0, 0);
        step(0, 0, 0, 8'h0, 8'h0, 8'h0, 1, 0, 0);
        idle(0, 3);
        idle(1, 6);
        check("drain_done_once", 32'(done_seen - d0), 32'd1);

        // Frame end with an empty buffer.
        d0 = done_seen;
        step(0, 0, 0, 8'h0, 8'h0, 8'h0, 1, 0, 1);
        idle(1, 2);
        check("empty_done_once", 32'(done_seen - d0), 32'd1);

        // Reset while holding five entries, then normal operation resumes.
        for (int i = 0; i < 5; i++) step(1, 30 + i, 40, 8'h77, 8'h66, 8'h55, 0, 0, 0);
        apply_reset();
        step(1, 1, 1, 8'hF0, 8'h0F, 8'hAA, 0, 0, 1);
        idle(1, 3);

        // Randomized traffic with a base that wraps the address space.
        i_fb_base = 24'hFFF000;
        idle(1, 1);
        for (int i = 0; i < 1500; i++) begin
            int  rx, ry;
            bit  wr, fe, clr, rdy;
            wr  = ($urandom_range(0, 9) < 7);
            rx  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 400)) - 40
                                               : int'($urandom_range(0, W - 1));
            ry  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 320)) - 40
                                               : int'($urandom_range(0, H - 1));
            fe  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 49) == 0);
            rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 3) == 0);
            step(wr, rx, ry, 8'($urandom), 8'($urandom), 8'($urandom), fe, clr, rdy);
        end
        idle(1, 12);
        check("final_empty", 32'(o_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/raster_pixel_writer.md
Name: raster_pixel_writer

Overview:
Consumer end of the raster pipeline's pixel-write interface: the write_pixel, x, y, r, g, b stream emitted by the vertex-color stage. It clips each pixel to the framebuffer, packs the colour to RGB565 and computes the linear framebuffer address. Results are buffered in a FIFO and issued on a valid/ready memory write port.
- Absorbs the upstream stream, which has no backpressure.
- Reports overflow and clipping.
- Signals frame-drain completion.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 240, framebuffer height in pixels
ADDR_W, 24, memory word-address width
FIFO_DEPTH, 8, total buffered entries; power of 2, at least 4
AF_LEVEL, 6, occupancy at or above which o_almost_full asserts

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_write_pixel  in  1  pixel-valid strobe, one pixel per cycle
i_x  in  16 signed  pixel x
i_y  in  16 signed  pixel y
i_r, i_g, i_b  in  8 each  colour
i_fb_base  in  ADDR_W  framebuffer base word address, quasi-static
i_frame_end  in  1  pulse: no more pixels for this frame
i_clear_status  in  1  clears o_overflow and o_clip_count
o_mem_valid  out  1  write request valid
i_mem_ready  in  1  memory accepts request
o_mem_addr  out  ADDR_W  word address
o_mem_data  out  16  RGB565 data
o_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
o_almost_full  out  1  o_level >= AF_LEVEL
o_overflow  out  1  sticky: an in-range pixel was dropped because the buffer was full
o_clip_count  out  16  clipped pixels, saturating
o_frame_done  out  1  one-cycle pulse when the frame drain completes

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - o_mem_valid=0, o_mem_addr=0, o_mem_data=0.
  - o_level=0, o_almost_full=0, o_overflow=0, o_clip_count=0, o_frame_done=0.
  - FSM=IDLE, FIFO pointers=0.
  - Reset mid-transfer discards all buffered entries.
- Clip: a pixel is clipped if x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT (signed compares).
  - A clipped pixel is not enqueued.
  - o_clip_count increments by 1 and saturates at 16'hFFFF.
- Address: i_fb_base + y*FB_WIDTH + x, computed in ADDR_W bits, wraps modulo 2^ADDR_W.
- Data: {r[7:3], g[7:2], b[7:3]}.
- Enqueue: an in-range pixel sampled at edge N is accepted if occupancy<FIFO_DEPTH, or if occupancy==FIFO_DEPTH and a pop also occurs at edge N.
  - Otherwise the pixel is dropped and o_overflow is set (sticky).
- Latency: with the buffer empty, a pixel sampled at edge N is presented on o_mem_valid/addr/data after edge N+1, so it is visible in cycle N+1.
- Handshake:
  - A pop occurs at an edge where o_mem_valid & i_mem_ready.
  - While valid and not ready, addr and data hold stable.
  - After a pop, the next entry is presented the following cycle, giving back-to-back throughput of 1 per cycle.
  - o_mem_valid never deasserts without a pop, except on reset.
- o_level updates as +push -pop per edge. o_almost_full is combinational from o_level.
- FSM:
  - IDLE: an i_frame_end pulse goes to DRAIN.
  - DRAIN: pixels are still accepted. When occupancy==0 and there is no pending push, pulse o_frame_done for 1 cycle and return to IDLE.
  - i_frame_end seen while in DRAIN is ignored.
  - i_frame_end with an empty buffer: o_frame_done pulses on the next cycle.
- i_clear_status: clears o_overflow and o_clip_count on that edge. A simultaneous overflow or clip event takes priority, giving overflow=1 and count=1.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by the extra pointer bit.

Decomposition:
- Shared package/header: the RGB565 pack macro and the clip-compare macro, alongside the existing fixed-point macros.
- Sub-module raster_pixel_fifo: synchronous FIFO of {addr, data}, width ADDR_W+16, with push, pop, count, full and empty, and a registered head output.
- The top level holds clip, address, packing, status and FSM logic.

Test Plan:
- Single pixel: base=0x1000, x=5, y=2, r=0xFF, g=0x80, b=0x08, ready=1 -> one request with addr=0x1285, data=0xFC01, valid exactly 1 cycle starting the cycle after input.
- Clipping: pixels at (-1,0), (320,0), (0,240), (319,239) -> only (319,239) issued, addr=base+76799; o_clip_count=3.
- Backpressure: ready=0, 8 pixels then 1 more -> o_level=8, o_almost_full=1, 9th dropped, o_overflow=1. Raise ready -> 8 requests in order on consecutive cycles.
- Simultaneous push/pop at full: level 8, ready=1, new pixel same cycle -> accepted, level stays 8, no overflow.
- Frame drain: 3 pixels, i_frame_end, ready held low 4 cycles then high -> o_frame_done pulses once, 1 cycle after the third pop.
- Reset mid-operation: level 5, assert i_rst_n=0 asynchronously -> o_mem_valid=0, o_level=0 immediately; after release, the next pixel is issued normally.
